// File: rtl/cbus_regfile.sv
// MIC-1 register bank behind the shifter: C-bus capture, B/H operand drive, MAR/MDR and PC/MBR memory ports.
// Latency: register writes and memory requests take effect one cycle after the microinstruction edge; B bus and H are combinational.
// Backpressure: none; a read or fetch that arrives while one of its kind is still outstanding is dropped and flags err.
//
// Ports: clk/rst (sync, active high); c_bus/c_en capture; b_sel -> b_bus, h_out;
//        mem_rd/mem_wr/mem_fetch issue; dmem_* data port (word address = MAR);
//        imem_* fetch port (byte address = PC); busy = read or fetch outstanding;
//        err = sticky protocol error.
module cbus_regfile #(
    parameter int NBITS = 32,
    parameter int B_SEL = 4,
    parameter int C_SEL = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] c_bus,
    input  logic [C_SEL-1:0] c_en,
    input  logic [B_SEL-1:0] b_sel,
    output logic [NBITS-1:0] b_bus,
    output logic [NBITS-1:0] h_out,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             mem_fetch,
    output logic [NBITS-1:0] dmem_addr,
    output logic [NBITS-1:0] dmem_wdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_rvalid,
    input  logic [NBITS-1:0] dmem_rdata,
    output logic [NBITS-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_rvalid,
    input  logic [7:0]       imem_rdata,
    output logic             busy,
    output logic             err
);

    // c_en bit positions
    localparam int EN_MAR = 0;
    localparam int EN_MDR = 1;
    localparam int EN_PC  = 2;
    localparam int EN_SP  = 3;
    localparam int EN_LV  = 4;
    localparam int EN_CPP = 5;
    localparam int EN_TOS = 6;
    localparam int EN_OPC = 7;
    localparam int EN_H   = 8;

    logic [NBITS-1:0] mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d;
    logic [NBITS-1:0] sp_q, sp_d, lv_q, lv_d, cpp_q, cpp_d;
    logic [NBITS-1:0] tos_q, tos_d, opc_q, opc_d, h_q, h_d;
    logic [7:0]       mbr_q, mbr_d;
    logic [NBITS-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [NBITS-1:0] imem_addr_q, imem_addr_d;
    logic             dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic             imem_req_q, imem_req_d;
    logic             rd_pend_q, rd_pend_d, f_pend_q, f_pend_d;
    logic             err_q, err_d;

    logic rd_done, f_done;   // response accepted this edge
    logic rd_hold, f_hold;   // still outstanding after this edge, ignoring new issue
    logic rd_req, rd_issue, f_issue;

    always_comb begin
        rd_done  = dmem_rvalid & rd_pend_q;
        f_done   = imem_rvalid & f_pend_q;
        rd_hold  = rd_pend_q & ~dmem_rvalid;
        f_hold   = f_pend_q & ~imem_rvalid;
        // a simultaneous read+write request degrades to a write
        rd_req   = mem_rd & ~mem_wr;
        rd_issue = rd_req & ~rd_hold;
        f_issue  = mem_fetch & ~f_hold;

        mar_d = c_en[EN_MAR] ? c_bus : mar_q;
        pc_d  = c_en[EN_PC]  ? c_bus : pc_q;
        sp_d  = c_en[EN_SP]  ? c_bus : sp_q;
        lv_d  = c_en[EN_LV]  ? c_bus : lv_q;
        cpp_d = c_en[EN_CPP] ? c_bus : cpp_q;
        tos_d = c_en[EN_TOS] ? c_bus : tos_q;
        opc_d = c_en[EN_OPC] ? c_bus : opc_q;
        h_d   = c_en[EN_H]   ? c_bus : h_q;
        // returning read data overrides a same-cycle C-bus write of MDR
        mdr_d = rd_done ? dmem_rdata : (c_en[EN_MDR] ? c_bus : mdr_q);
        mbr_d = f_done ? imem_rdata : mbr_q;

        // port copies track the post-write values so "MAR=x; rd" addresses x
        dmem_addr_d  = mar_d;
        dmem_wdata_d = mdr_d;
        imem_addr_d  = pc_d;

        dmem_req_d = rd_issue | mem_wr;
        dmem_we_d  = mem_wr;
        imem_req_d = f_issue;

        rd_pend_d = rd_hold | rd_issue;
        f_pend_d  = f_hold | f_issue;

        err_d = err_q
              | (mem_rd & mem_wr)
              | (rd_req & rd_hold)
              | (mem_wr & rd_hold)
              | (mem_fetch & f_hold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q        <= '0;
            mdr_q        <= '0;
            pc_q         <= '0;
            mbr_q        <= '0;
            sp_q         <= '0;
            lv_q         <= '0;
            cpp_q        <= '0;
            tos_q        <= '0;
            opc_q        <= '0;
            h_q          <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_addr_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            imem_req_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            f_pend_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            pc_q         <= pc_d;
            mbr_q        <= mbr_d;
            sp_q         <= sp_d;
            lv_q         <= lv_d;
            cpp_q        <= cpp_d;
            tos_q        <= tos_d;
            opc_q        <= opc_d;
            h_q          <= h_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            imem_addr_q  <= imem_addr_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            imem_req_q   <= imem_req_d;
            rd_pend_q    <= rd_pend_d;
            f_pend_q     <= f_pend_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        b_bus = '0;
        case (b_sel)
            4'd0: b_bus = mdr_q;
            4'd1: b_bus = pc_q;
            4'd2: b_bus = {{(NBITS-8){mbr_q[7]}}, mbr_q};
            4'd3: b_bus = {{(NBITS-8){1'b0}}, mbr_q};
            4'd4: b_bus = sp_q;
            4'd5: b_bus = lv_q;
            4'd6: b_bus = cpp_q;
            4'd7: b_bus = tos_q;
            4'd8: b_bus = opc_q;
            default: b_bus = '0;
        endcase
    end

    assign h_out      = h_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_req   = imem_req_q;
    assign busy       = rd_pend_q | f_pend_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cbus_regfile.sv
// Directed vector bench for cbus_regfile: one table of single-cycle records plus a few hand sequences.
// Each record is applied before a rising edge; outputs are compared 1 ns after that edge.
// Expected values are hand-computed from the register-bank behaviour.
module tb_cbus_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_bus;
    logic [8:0]  c_en;
    logic [3:0]  b_sel;
    logic [31:0] b_bus, h_out;
    logic        mem_rd, mem_wr, mem_fetch;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_req, dmem_we, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] imem_addr;
    logic        imem_req, imem_rvalid;
    logic [7:0]  imem_rdata;
    logic        busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cbus_regfile dut (
        .clk(clk), .rst(rst), .c_bus(c_bus), .c_en(c_en), .b_sel(b_sel),
        .b_bus(b_bus), .h_out(h_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_fetch(mem_fetch),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .busy(busy), .err(err)
    );

    typedef struct {
        logic        rst;
        logic [31:0] c_bus;
        logic [8:0]  c_en;
        logic [3:0]  b_sel;
        logic        rd, wr, fetch;
        logic        drv;
        logic [31:0] ddata;
        logic        irv;
        logic [7:0]  idata;
        logic [31:0] e_b, e_h, e_daddr, e_wdata, e_iaddr;
        logic        e_dreq, e_we, e_ireq, e_busy, e_err;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] cb, input logic [8:0] ce, input logic [3:0] bs,
                         input logic rd, input logic wr, input logic f,
                         input logic drv, input logic [31:0] dd, input logic irv, input logic [7:0] id);
        rst = r; c_bus = cb; c_en = ce; b_sel = bs;
        mem_rd = rd; mem_wr = wr; mem_fetch = f;
        dmem_rvalid = drv; dmem_rdata = dd; imem_rvalid = irv; imem_rdata = id;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst  c_bus         c_en    sel   rd wr f  drv ddata          irv idata   b              h      daddr  wdata          iaddr  dreq we ireq busy err
        vt[0]  = '{1'b1, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h0, 32'h0,  32'h0,         32'h0,  0, 0, 0, 0, 0};
        vt[1]  = '{1'b0, 32'h5,        9'h1FF, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[2]  = '{1'b0, 32'h0,        9'h000, 4'd1, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[3]  = '{1'b0, 32'h0,        9'h000, 4'd2, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[4]  = '{1'b0, 32'h0,        9'h000, 4'd3, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[5]  = '{1'b0, 32'h0,        9'h000, 4'd4, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[6]  = '{1'b0, 32'h0,        9'h000, 4'd5, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[7]  = '{1'b0, 32'h0,        9'h000, 4'd6, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[8]  = '{1'b0, 32'h0,        9'h000, 4'd7, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[9]  = '{1'b0, 32'h0,        9'h000, 4'd8, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        vt[10] = '{1'b0, 32'h0,        9'h000, 4'd12,0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h5, 32'h5,  32'h5,         32'h5,  0, 0, 0, 0, 0};
        // MAR=0x40 with read; data returns two cycles later
        vt[11] = '{1'b0, 32'h40,       9'h001, 4'd0, 1, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h40, 32'h5,         32'h5,  1, 0, 0, 1, 0};
        vt[12] = '{1'b0, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h5,         32'h5, 32'h40, 32'h5,         32'h5,  0, 0, 0, 1, 0};
        vt[13] = '{1'b0, 32'h0,        9'h000, 4'd0, 0, 0, 0, 1, 32'hDEADBEEF,  0, 8'h00, 32'hDEADBEEF,  32'h5, 32'h40, 32'hDEADBEEF,  32'h5,  0, 0, 0, 0, 0};
        // PC=0x10 with fetch, byte 0x80 returns next cycle
        vt[14] = '{1'b0, 32'h10,       9'h004, 4'd1, 0, 0, 1, 0, 32'h0,         0, 8'h00, 32'h10,        32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 0, 0, 1, 1, 0};
        vt[15] = '{1'b0, 32'h0,        9'h000, 4'd2, 0, 0, 0, 0, 32'h0,         1, 8'h80, 32'hFFFFFF80,  32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 0, 0, 0, 0, 0};
        vt[16] = '{1'b0, 32'h0,        9'h000, 4'd3, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h80,        32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 0, 0, 0, 0, 0};
        // second read while pending is dropped and sets err
        vt[17] = '{1'b0, 32'h0,        9'h000, 4'd0, 1, 0, 0, 0, 32'h0,         0, 8'h00, 32'hDEADBEEF,  32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 1, 0, 0, 1, 0};
        vt[18] = '{1'b0, 32'h0,        9'h000, 4'd0, 1, 0, 0, 0, 32'h0,         0, 8'h00, 32'hDEADBEEF,  32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 0, 0, 0, 1, 1};
        vt[19] = '{1'b0, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'hDEADBEEF,  32'h5, 32'h40, 32'hDEADBEEF,  32'h10, 0, 0, 0, 1, 1};
        // response vs C-bus write of MDR: memory wins
        vt[20] = '{1'b0, 32'h22,       9'h002, 4'd0, 0, 0, 0, 1, 32'h11,        0, 8'h00, 32'h11,        32'h5, 32'h40, 32'h11,         32'h10, 0, 0, 0, 0, 1};
        vt[21] = '{1'b1, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h0, 32'h0,  32'h0,         32'h0,  0, 0, 0, 0, 0};
        // read abandoned by reset; late rvalid ignored
        vt[22] = '{1'b0, 32'h0,        9'h000, 4'd0, 1, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h0, 32'h0,  32'h0,         32'h0,  1, 0, 0, 1, 0};
        vt[23] = '{1'b1, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h0,         32'h0, 32'h0,  32'h0,         32'h0,  0, 0, 0, 0, 0};
        vt[24] = '{1'b0, 32'h0,        9'h000, 4'd0, 0, 0, 0, 1, 32'hCAFE,      0, 8'h00, 32'h0,         32'h0, 32'h0,  32'h0,         32'h0,  0, 0, 0, 0, 0};
        // write with MAR/MDR loaded in the same microinstruction
        vt[25] = '{1'b0, 32'h77,       9'h003, 4'd0, 0, 1, 0, 0, 32'h0,         0, 8'h00, 32'h77,        32'h0, 32'h77, 32'h77,         32'h0,  1, 1, 0, 0, 0};
        vt[26] = '{1'b0, 32'h0,        9'h000, 4'd0, 0, 0, 0, 0, 32'h0,         0, 8'h00, 32'h77,        32'h0, 32'h77, 32'h77,         32'h0,  0, 0, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].c_bus, vt[i].c_en, vt[i].b_sel, vt[i].rd, vt[i].wr, vt[i].fetch,
                  vt[i].drv, vt[i].ddata, vt[i].irv, vt[i].idata);
            chk($sformatf("v%0d b_bus", i),      b_bus,      vt[i].e_b);
            chk($sformatf("v%0d h_out", i),      h_out,      vt[i].e_h);
            chk($sformatf("v%0d dmem_addr", i),  dmem_addr,  vt[i].e_daddr);
            chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d imem_addr", i),  imem_addr,  vt[i].e_iaddr);
            chk($sformatf("v%0d dmem_req", i),   {31'b0, dmem_req}, {31'b0, vt[i].e_dreq});
            chk($sformatf("v%0d dmem_we", i),    {31'b0, dmem_we},  {31'b0, vt[i].e_we});
            chk($sformatf("v%0d imem_req", i),   {31'b0, imem_req}, {31'b0, vt[i].e_ireq});
            chk($sformatf("v%0d busy", i),       {31'b0, busy},     {31'b0, vt[i].e_busy});
            chk($sformatf("v%0d err", i),        {31'b0, err},      {31'b0, vt[i].e_err});
        end

        // response and re-issue in the same cycle keep the read outstanding without error
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 1, 32'h33, 0, 0);
        chk("reissue dmem_req", {31'b0, dmem_req}, 32'd1);
        chk("reissue busy",     {31'b0, busy},     32'd1);
        chk("reissue err",      {31'b0, err},      32'd0);
        chk("reissue mdr",      b_bus,             32'h33);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        chk("reissue done busy", {31'b0, busy}, 32'd0);
        chk("reissue done mdr",  b_bus,         32'h44);

        // fetch re-issue with same-cycle response
        drive(0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 8'h7F);
        chk("fetch reissue imem_req", {31'b0, imem_req}, 32'd1);
        chk("fetch reissue busy",     {31'b0, busy},     32'd1);
        chk("fetch reissue mbr",      b_bus,             32'h7F);
        drive(0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
        chk("fetch dropped imem_req", {31'b0, imem_req}, 32'd0);
        chk("fetch dropped err",      {31'b0, err},      32'd1);

        // read+write together: write wins, err set
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("rdwr dmem_req", {31'b0, dmem_req}, 32'd1);
        chk("rdwr dmem_we",  {31'b0, dmem_we},  32'd1);
        chk("rdwr busy",     {31'b0, busy},     32'd0);
        chk("rdwr err",      {31'b0, err},      32'd1);

        // write while a read is outstanding: issued, but MDR hazard flagged
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("hazard dmem_req", {31'b0, dmem_req}, 32'd1);
        chk("hazard dmem_we",  {31'b0, dmem_we},  32'd1);
        chk("hazard busy",     {31'b0, busy},     32'd1);
        chk("hazard err",      {31'b0, err},      32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
